// File: rtl/alu_result_sel.sv
// Registered ALU result selector: latches a one-hot unit select, waits for that
// unit's done strobe (bounded by a timeout), and holds the result on a valid/ready port.
module alu_result_sel #(
  parameter int WIDTH   = 7,
  parameter int NUM_OPS = 6,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_OPS*WIDTH-1:0]   op_res,
  input  logic [NUM_OPS-1:0]         op_done,
  input  logic [NUM_OPS-1:0]         sel,
  input  logic                       start,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic [1:0]                 err_code
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BAD_SEL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } stateT;

  stateT              stateQ, stateNext;
  logic [NUM_OPS-1:0] selQ, selNext;
  logic [CNT_W-1:0]   cntQ, cntNext;
  logic [WIDTH-1:0]   dataQ, dataNext;
  logic               zeroQ, zeroNext;
  logic [1:0]         errQ, errNext;
  logic               busyQ, validQ;

  logic               selDone;
  logic [WIDTH-1:0]   selSlice;

  function automatic logic isOneHot(input logic [NUM_OPS-1:0] v);
    return (v != '0) && ((v & (v - NUM_OPS'(1))) == '0);
  endfunction

  // selQ is one-hot whenever it is consulted, so an AND-OR mux is sufficient
  always_comb begin
    selDone  = 1'b0;
    selSlice = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (selQ[i]) begin
        selDone  = selDone | op_done[i];
        selSlice = selSlice | op_res[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    stateNext = stateQ;
    selNext   = selQ;
    cntNext   = cntQ;
    dataNext  = dataQ;
    zeroNext  = zeroQ;
    errNext   = errQ;

    unique case (stateQ)
      ST_IDLE, ST_HOLD: begin
        // A completed handshake with start pending issues immediately, same as IDLE
        if (stateQ == ST_IDLE || out_ready) begin
          if (start) begin
            selNext = sel;
            if (isOneHot(sel)) begin
              stateNext = ST_WAIT;
              cntNext   = '0;
            end else begin
              stateNext = ST_HOLD;
              dataNext  = '0;
              zeroNext  = 1'b0;
              errNext   = ERR_BAD_SEL;
            end
          end else begin
            stateNext = ST_IDLE;
          end
        end
      end

      ST_WAIT: begin
        if (selDone) begin
          stateNext = ST_HOLD;
          dataNext  = selSlice;
          zeroNext  = (selSlice == '0);
          errNext   = ERR_OK;
        end else if (cntQ == CNT_W'(TIMEOUT - 1)) begin
          stateNext = ST_HOLD;
          dataNext  = '0;
          zeroNext  = 1'b0;
          errNext   = ERR_TIMEOUT;
        end else begin
          cntNext = cntQ + CNT_W'(1);
        end
      end

      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= ST_IDLE;
      selQ   <= '0;
      cntQ   <= '0;
      dataQ  <= '0;
      zeroQ  <= 1'b0;
      errQ   <= ERR_OK;
      busyQ  <= 1'b0;
      validQ <= 1'b0;
    end else begin
      stateQ <= stateNext;
      selQ   <= selNext;
      cntQ   <= cntNext;
      dataQ  <= dataNext;
      zeroQ  <= zeroNext;
      errQ   <= errNext;
      busyQ  <= (stateNext != ST_IDLE);
      validQ <= (stateNext == ST_HOLD);
    end
  end

  assign busy      = busyQ;
  assign out_valid = validQ;
  assign out_data  = dataQ;
  assign out_zero  = zeroQ;
  assign err_code  = errQ;

endmodule

// File: tb/tb_alu_result_sel.sv
// Directed self-checking bench for alu_result_sel (WIDTH=7, NUM_OPS=6, TIMEOUT=4).
module tb_alu_result_sel;

  localparam int W = 7;
  localparam int N = 6;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] opRes;
  logic [N-1:0]   opDone;
  logic [N-1:0]   sel;
  logic           start;
  logic           busy;
  logic           outValid;
  logic           outReady;
  logic [W-1:0]   outData;
  logic           outZero;
  logic [1:0]     errCode;

  int testsRun = 0;
  int testsFailed = 0;

  alu_result_sel #(.WIDTH(W), .NUM_OPS(N), .TIMEOUT(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_res   (opRes),
    .op_done  (opDone),
    .sel      (sel),
    .start    (start),
    .busy     (busy),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data (outData),
    .out_zero (outZero),
    .err_code (errCode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic b, input logic v,
                        input logic [W-1:0] d, input logic z, input logic [1:0] e);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".valid"}, 32'(outValid), 32'(v));
    chk({tag, ".data"}, 32'(outData), 32'(d));
    chk({tag, ".zero"}, 32'(outZero), 32'(z));
    chk({tag, ".err"}, 32'(errCode), 32'(e));
  endtask

  task automatic setRes(input int idx, input logic [W-1:0] val);
    opRes[idx*W +: W] = val;
  endtask

  initial begin
    rst_n    = 1'b0;
    opRes    = '0;
    opDone   = '0;
    sel      = '0;
    start    = 1'b0;
    outReady = 1'b0;
    tick();
    tick();
    chkOut("reset", 0, 0, 7'h00, 0, 2'b00);
    rst_n = 1'b1;
    tick();
    chkOut("postReset", 0, 0, 7'h00, 0, 2'b00);

    // Minimum-latency capture on unit 0
    sel = 6'b000001; start = 1'b1; outReady = 1'b1;
    setRes(0, 7'h2A); setRes(3, 7'h13);
    tick();
    start = 1'b0; opDone = 6'b000001;
    chk("t1.waitBusy", 32'(busy), 32'd1);
    chk("t1.waitValid", 32'(outValid), 32'd0);
    tick();
    opDone = '0;
    chkOut("t1.hold", 1, 1, 7'h2A, 0, 2'b00);
    tick();
    chkOut("t1.idle", 0, 0, 7'h2A, 0, 2'b00);

    // Multiplier-style late done with zero result, consumer stall
    sel = 6'b100000; start = 1'b1; outReady = 1'b0;
    setRes(5, 7'h00);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t2.stillWait", 32'(outValid), 32'd0);
    opDone = 6'b100000;
    tick();
    opDone = '0;
    chkOut("t2.hold", 1, 1, 7'h00, 1, 2'b00);
    tick();
    chkOut("t2.stall1", 1, 1, 7'h00, 1, 2'b00);
    tick();
    chkOut("t2.stall2", 1, 1, 7'h00, 1, 2'b00);
    outReady = 1'b1;
    tick();
    chkOut("t2.idle", 0, 0, 7'h00, 1, 2'b00);

    // Bad selects: two bits, then none
    sel = 6'b000110; start = 1'b1;
    tick();
    start = 1'b0;
    chkOut("t3.multiHot", 1, 1, 7'h00, 0, 2'b01);
    tick();
    chk("t3.idleA", 32'(busy), 32'd0);
    sel = 6'b000000; start = 1'b1;
    tick();
    start = 1'b0;
    chkOut("t3.noneHot", 1, 1, 7'h00, 0, 2'b01);
    tick();
    chk("t3.idleB", 32'(busy), 32'd0);

    // Timeout with an unselected done strobe in flight
    sel = 6'b000100; start = 1'b1;
    setRes(2, 7'h11); setRes(1, 7'h66);
    tick();
    start = 1'b0; opDone = 6'b000010;
    tick();
    opDone = '0;
    chk("t4.ignoreOther", 32'(outValid), 32'd0);
    tick();
    tick();
    chkOut("t4.wait4", 1, 0, 7'h00, 0, 2'b01);
    tick();
    chkOut("t4.timeout", 1, 1, 7'h00, 0, 2'b10);

    // Back-to-back reissue; done arrives on the last allowed WAIT cycle
    sel = 6'b000100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4b.wait", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    chk("t4b.notYet", 32'(outValid), 32'd0);
    opDone = 6'b000100;
    tick();
    opDone = '0;
    chkOut("t4b.capture", 1, 1, 7'h11, 0, 2'b00);

    // Handshake plus start: no idle bubble
    sel = 6'b010000; start = 1'b1;
    setRes(4, 7'h55);
    tick();
    start = 1'b0; opDone = 6'b010000;
    chk("t5.noBubbleBusy", 32'(busy), 32'd1);
    chk("t5.noBubbleValid", 32'(outValid), 32'd0);
    tick();
    opDone = '0;
    chkOut("t5.second", 1, 1, 7'h55, 0, 2'b00);

    // Start during stalled HOLD is ignored
    outReady = 1'b0; sel = 6'b000001; start = 1'b1; opDone = 6'b000001;
    tick();
    chkOut("t5.ignored1", 1, 1, 7'h55, 0, 2'b00);
    tick();
    start = 1'b0; opDone = '0;
    chkOut("t5.ignored2", 1, 1, 7'h55, 0, 2'b00);
    outReady = 1'b1;
    tick();
    chk("t5.idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-WAIT
    sel = 6'b000001; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.inWait", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chkOut("t6.rstWait", 0, 0, 7'h00, 0, 2'b00);
    rst_n = 1'b1;
    opDone = 6'b000001;
    tick();
    opDone = '0;
    chkOut("t6.afterWait", 0, 0, 7'h00, 0, 2'b00);

    // Asynchronous reset mid-HOLD with a nonzero result held
    outReady = 1'b0; sel = 6'b000010; start = 1'b1;
    setRes(1, 7'h7F);
    tick();
    start = 1'b0; opDone = 6'b000010;
    tick();
    opDone = '0;
    chkOut("t6.hold", 1, 1, 7'h7F, 0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chkOut("t6.rstHold", 0, 0, 7'h00, 0, 2'b00);
    rst_n = 1'b1;
    tick();
    tick();
    chkOut("t6.afterHold", 0, 0, 7'h00, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
